// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg: shared register-file constants and scoreboard mask helper
package issue_ctrl_pkg;
  localparam int NREG = 32;
  localparam int REG_IDX_W = 5;
  localparam int PERF_W = 32;
  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  function automatic logic [NREG-1:0] idx_mask(input logic en, input reg_idx_t i);
    return (en && i != REG_X0) ? NREG'(1) << i : '0;
  endfunction
endpackage

// File: rtl/issue_ctrl_if.sv
// issue_if: decode/execute/LSU/status signal bundle of issue_ctrl
// ports: master = decode/EX/LSU side driving requests, slave = issue_ctrl
interface issue_if #(parameter int PC_W = 64);
  import issue_ctrl_pkg::*;
  logic flush, id_valid, id_ready;
  logic [31:0] id_insn;
  logic [PC_W-1:0] id_pc;
  logic id_rs1_re, id_rs2_re, id_rf_we, id_ld;
  reg_idx_t id_rs1_addr, id_rs2_addr, id_rd;
  logic ex_valid, ex_ready, ex_rf_we, ex_ld;
  logic [31:0] ex_insn;
  logic [PC_W-1:0] ex_pc;
  reg_idx_t ex_rd;
  logic lsu_wb_valid;
  reg_idx_t lsu_wb_rd;
  logic [NREG-1:0] sb_pending;
  logic [3:0] ld_outstanding;
  logic [PERF_W-1:0] stall_cycles;
  logic sb_err;
  modport master (
    output flush, id_valid, id_insn, id_pc, id_rs1_re, id_rs1_addr, id_rs2_re, id_rs2_addr,
           id_rf_we, id_rd, id_ld, ex_ready, lsu_wb_valid, lsu_wb_rd,
    input  id_ready, ex_valid, ex_insn, ex_pc, ex_rf_we, ex_rd, ex_ld,
           sb_pending, ld_outstanding, stall_cycles, sb_err
  );
  modport slave (
    input  flush, id_valid, id_insn, id_pc, id_rs1_re, id_rs1_addr, id_rs2_re, id_rs2_addr,
           id_rf_we, id_rd, id_ld, ex_ready, lsu_wb_valid, lsu_wb_rd,
    output id_ready, ex_valid, ex_insn, ex_pc, ex_rf_we, ex_rd, ex_ld,
           sb_pending, ld_outstanding, stall_cycles, sb_err
  );
endinterface

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: pending-load register bitmap with set/clear and error detect
// ports: i_set/i_set_idx mark, i_clr/i_clr_idx release, i_rs1/i_rs2/i_rd lookups, o_err protocol error
module issue_scoreboard import issue_ctrl_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic i_set,
  input  reg_idx_t i_set_idx,
  input  logic i_clr,
  input  reg_idx_t i_clr_idx,
  input  reg_idx_t i_rs1,
  input  reg_idx_t i_rs2,
  input  reg_idx_t i_rd,
  output logic [NREG-1:0] o_pend,
  output logic o_hit_rs1,
  output logic o_hit_rs2,
  output logic o_hit_rd,
  output logic o_err
);
  logic [NREG-1:0] r_pend, w_set, w_clr;
  always_comb begin
    w_set = idx_mask(i_set, i_set_idx);
    w_clr = idx_mask(i_clr, i_clr_idx);
  end
  // clearing an idle entry or colliding with a same-cycle set is a protocol error
  assign o_err = |(w_clr & (w_set | ~r_pend));
  always_ff @(posedge clk)
    if (rst) r_pend <= '0;
    else r_pend <= (r_pend & ~w_clr) | w_set;
  assign o_pend = r_pend;
  assign o_hit_rs1 = r_pend[i_rs1];
  assign o_hit_rs2 = r_pend[i_rs2];
  assign o_hit_rd = r_pend[i_rd];
endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: ID->EX issue register with load scoreboard, load credits and stall counter
// ports: clk, rst (sync, active high), bus (issue_if.slave: decode, EX handshake, LSU writeback, status)
module issue_ctrl import issue_ctrl_pkg::*; #(
  parameter int MAX_LD = 2,
  parameter int PC_W = 64
) (
  input logic clk,
  input logic rst,
  issue_if.slave bus
);
  logic w_hit1, w_hit2, w_hitd, w_sb_err;
  logic w_raw1, w_raw2, w_waw, w_no_credit, w_issue, w_inc, w_dec, w_cnt_err;
  logic r_exv, r_we, r_ld, r_err;
  logic [31:0] r_insn;
  logic [PC_W-1:0] r_pc;
  reg_idx_t r_rd;
  logic [3:0] r_cnt;
  logic [PERF_W-1:0] r_stall;
  issue_scoreboard u_sb (
    .clk(clk), .rst(rst),
    .i_set(w_issue & bus.id_ld & bus.id_rf_we), .i_set_idx(bus.id_rd),
    .i_clr(bus.lsu_wb_valid), .i_clr_idx(bus.lsu_wb_rd),
    .i_rs1(bus.id_rs1_addr), .i_rs2(bus.id_rs2_addr), .i_rd(bus.id_rd),
    .o_pend(bus.sb_pending), .o_hit_rs1(w_hit1), .o_hit_rs2(w_hit2), .o_hit_rd(w_hitd),
    .o_err(w_sb_err)
  );
  // hazards use registered state only: a same-cycle writeback does not unblock issue
  always_comb begin
    w_raw1 = bus.id_rs1_re & (bus.id_rs1_addr != REG_X0) & w_hit1;
    w_raw2 = bus.id_rs2_re & (bus.id_rs2_addr != REG_X0) & w_hit2;
    w_waw = bus.id_rf_we & (bus.id_rd != REG_X0) & w_hitd;
    w_no_credit = bus.id_ld & (r_cnt == 4'(MAX_LD));
    w_issue = bus.id_valid & ~bus.flush & (~r_exv | bus.ex_ready) & ~w_raw1 & ~w_raw2 & ~w_waw & ~w_no_credit;
    w_inc = w_issue & bus.id_ld;
    w_dec = bus.lsu_wb_valid & (r_cnt != 4'd0);
    w_cnt_err = bus.lsu_wb_valid & (r_cnt == 4'd0);
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_exv <= 1'b0;
      r_insn <= '0;
      r_pc <= '0;
      r_we <= 1'b0;
      r_rd <= '0;
      r_ld <= 1'b0;
      r_cnt <= '0;
      r_stall <= '0;
      r_err <= 1'b0;
    end else begin
      if (bus.flush) r_exv <= 1'b0;
      else if (w_issue) begin
        r_exv <= 1'b1;
        r_insn <= bus.id_insn;
        r_pc <= bus.id_pc;
        r_we <= bus.id_rf_we;
        r_rd <= bus.id_rd;
        r_ld <= bus.id_ld;
      end else if (bus.ex_ready) r_exv <= 1'b0;
      r_cnt <= r_cnt + 4'(w_inc) - 4'(w_dec);
      r_stall <= r_stall + PERF_W'(bus.id_valid & ~w_issue & ~bus.flush);
      r_err <= r_err | w_sb_err | w_cnt_err;
    end
  assign bus.id_ready = w_issue;
  assign bus.ex_valid = r_exv;
  assign bus.ex_insn = r_insn;
  assign bus.ex_pc = r_pc;
  assign bus.ex_rf_we = r_we;
  assign bus.ex_rd = r_rd;
  assign bus.ex_ld = r_ld;
  assign bus.ld_outstanding = r_cnt;
  assign bus.stall_cycles = r_stall;
  assign bus.sb_err = r_err;
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: table-driven directed check of issue_ctrl with MAX_LD=2
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  issue_if #(.PC_W(64)) bus();
  issue_ctrl #(.MAX_LD(2), .PC_W(64)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct {
    logic val, fl, exr, r1e;
    logic [4:0] r1;
    logic r2e;
    logic [4:0] r2;
    logic we;
    logic [4:0] rd;
    logic ld, wb;
    logic [4:0] wbrd;
    logic rdy, exv;
    logic [31:0] pend;
    logic [3:0] cnt;
    logic err;
    logic [31:0] stall;
  } vec_t;
  vec_t tv[$];
  int n = 0;
  int nerr = 0;
  logic [31:0] last_insn;
  logic [4:0] last_rd;
  function automatic vec_t mk(logic val, fl, exr, r1e, logic [4:0] r1, logic r2e, logic [4:0] r2,
                              logic we, logic [4:0] rd, logic ld, wb, logic [4:0] wbrd,
                              logic rdy, exv, logic [31:0] pend, logic [3:0] cnt, logic err, logic [31:0] stall);
    vec_t t;
    t.val = val; t.fl = fl; t.exr = exr; t.r1e = r1e; t.r1 = r1; t.r2e = r2e; t.r2 = r2;
    t.we = we; t.rd = rd; t.ld = ld; t.wb = wb; t.wbrd = wbrd;
    t.rdy = rdy; t.exv = exv; t.pend = pend; t.cnt = cnt; t.err = err; t.stall = stall;
    return t;
  endfunction
  function automatic logic [63:0] pc_of(logic [31:0] insn);
    return 64'hA000_0000_0000_0000 | (64'(insn) << 2);
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(vec_t t, logic [31:0] insn);
    bus.id_valid = t.val; bus.flush = t.fl; bus.ex_ready = t.exr;
    bus.id_rs1_re = t.r1e; bus.id_rs1_addr = t.r1; bus.id_rs2_re = t.r2e; bus.id_rs2_addr = t.r2;
    bus.id_rf_we = t.we; bus.id_rd = t.rd; bus.id_ld = t.ld;
    bus.lsu_wb_valid = t.wb; bus.lsu_wb_rd = t.wbrd;
    bus.id_insn = insn; bus.id_pc = pc_of(insn);
  endtask
  initial begin
    //      val fl exr r1e r1 r2e r2 we rd ld wb wbrd | rdy exv pend cnt err stall
    tv.push_back(mk(1,0,1, 1,0, 0,0, 1,1, 0, 0,0,  1,1,32'h0,0,0,0));
    tv.push_back(mk(1,0,1, 1,1, 1,1, 1,2, 0, 0,0,  1,1,32'h0,0,0,0));
    tv.push_back(mk(1,0,1, 1,0, 0,0, 1,5, 1, 0,0,  1,1,32'h20,1,0,0));
    tv.push_back(mk(1,0,1, 1,5, 1,0, 1,6, 0, 0,0,  0,0,32'h20,1,0,1));
    tv.push_back(mk(1,0,1, 1,5, 1,0, 1,6, 0, 0,0,  0,0,32'h20,1,0,2));
    tv.push_back(mk(1,0,1, 1,5, 1,0, 1,6, 0, 0,0,  0,0,32'h20,1,0,3));
    tv.push_back(mk(1,0,1, 1,5, 1,0, 1,6, 0, 1,5,  0,0,32'h0,0,0,4));
    tv.push_back(mk(1,0,1, 1,5, 1,0, 1,6, 0, 0,0,  1,1,32'h0,0,0,4));
    tv.push_back(mk(1,0,1, 1,0, 0,0, 1,1, 1, 0,0,  1,1,32'h2,1,0,4));
    tv.push_back(mk(1,0,1, 1,0, 0,0, 1,2, 1, 0,0,  1,1,32'h6,2,0,4));
    tv.push_back(mk(1,0,1, 1,0, 0,0, 1,3, 1, 0,0,  0,0,32'h6,2,0,5));
    tv.push_back(mk(1,0,1, 1,0, 0,0, 1,3, 1, 1,1,  0,0,32'h4,1,0,6));
    tv.push_back(mk(1,0,1, 1,0, 0,0, 1,3, 1, 0,0,  1,1,32'hC,2,0,6));
    tv.push_back(mk(1,0,0, 1,0, 1,0, 1,10,0, 0,0,  0,1,32'hC,2,0,7));
    tv.push_back(mk(1,0,1, 1,0, 1,0, 1,10,0, 0,0,  1,1,32'hC,2,0,7));
    tv.push_back(mk(0,0,1, 0,0, 0,0, 0,0, 0, 1,2,  0,0,32'h8,1,0,7));
    tv.push_back(mk(0,0,1, 0,0, 0,0, 0,0, 0, 1,3,  0,0,32'h0,0,0,7));
    tv.push_back(mk(1,0,1, 1,0, 0,0, 1,7, 1, 0,0,  1,1,32'h80,1,0,7));
    tv.push_back(mk(1,0,0, 1,0, 0,0, 1,7, 0, 0,0,  0,1,32'h80,1,0,8));
    tv.push_back(mk(1,1,0, 1,0, 0,0, 1,11,0, 0,0,  0,0,32'h80,1,0,8));
    tv.push_back(mk(0,0,1, 0,0, 0,0, 0,0, 0, 1,7,  0,0,32'h0,0,0,8));
    tv.push_back(mk(1,0,1, 1,0, 0,0, 1,0, 1, 0,0,  1,1,32'h0,1,0,8));
    tv.push_back(mk(0,0,1, 0,0, 0,0, 0,0, 0, 1,0,  0,0,32'h0,0,0,8));
    tv.push_back(mk(1,0,1, 1,0, 0,0, 1,4, 1, 0,0,  1,1,32'h10,1,0,8));
    tv.push_back(mk(0,0,1, 0,0, 0,0, 0,0, 0, 1,9,  0,0,32'h10,0,1,8));
    tv.push_back(mk(0,0,1, 0,0, 0,0, 0,0, 0, 0,0,  0,0,32'h10,0,1,8));
    tv.push_back(mk(0,0,1, 0,0, 0,0, 0,0, 0, 1,4,  0,0,32'h0,0,1,8));
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
    chk("rst_pend", 64'(bus.sb_pending), 64'd0);
    chk("rst_cnt", 64'(bus.ld_outstanding), 64'd0);
    chk("rst_err", 64'(bus.sb_err), 64'd0);
    chk("rst_stall", 64'(bus.stall_cycles), 64'd0);
    chk("rst_insn", 64'(bus.ex_insn), 64'd0);
    rst = 1'b0;
    last_insn = '0;
    last_rd = '0;
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i], 32'h1000 + 32'(i));
      #4;
      chk($sformatf("v%0d_id_ready", i), 64'(bus.id_ready), 64'(tv[i].rdy));
      if (tv[i].rdy) begin
        last_insn = 32'h1000 + 32'(i);
        last_rd = tv[i].rd;
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ex_valid", i), 64'(bus.ex_valid), 64'(tv[i].exv));
      chk($sformatf("v%0d_pend", i), 64'(bus.sb_pending), 64'(tv[i].pend));
      chk($sformatf("v%0d_cnt", i), 64'(bus.ld_outstanding), 64'(tv[i].cnt));
      chk($sformatf("v%0d_err", i), 64'(bus.sb_err), 64'(tv[i].err));
      chk($sformatf("v%0d_stall", i), 64'(bus.stall_cycles), 64'(tv[i].stall));
      if (tv[i].exv) begin
        chk($sformatf("v%0d_ex_insn", i), 64'(bus.ex_insn), 64'(last_insn));
        chk($sformatf("v%0d_ex_pc", i), bus.ex_pc, pc_of(last_insn));
        chk($sformatf("v%0d_ex_rd", i), 64'(bus.ex_rd), 64'(last_rd));
      end
    end
    rst = 1'b1;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), 32'h0);
    @(posedge clk);
    #1;
    chk("rst2_err", 64'(bus.sb_err), 64'd0);
    chk("rst2_stall", 64'(bus.stall_cycles), 64'd0);
    chk("rst2_ex_valid", 64'(bus.ex_valid), 64'd0);
    rst = 1'b0;
    drive(mk(1,0,1,1,0,0,0,1,12,0,0,0,0,0,0,0,0,0), 32'hAAAA_0001);
    @(posedge clk);
    #1;
    chk("hold_first_ex_valid", 64'(bus.ex_valid), 64'd1);
    chk("hold_first_ex_ld", 64'(bus.ex_ld), 64'd0);
    chk("hold_first_ex_we", 64'(bus.ex_rf_we), 64'd1);
    for (int k = 0; k < 3; k++) begin
      drive(mk(1,0,0,1,0,0,0,1,13,1,0,0,0,0,0,0,0,0), 32'hBBBB_0002);
      #4;
      chk($sformatf("hold%0d_id_ready", k), 64'(bus.id_ready), 64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_ex_valid", k), 64'(bus.ex_valid), 64'd1);
      chk($sformatf("hold%0d_ex_insn", k), 64'(bus.ex_insn), 64'hAAAA_0001);
      chk($sformatf("hold%0d_ex_pc", k), bus.ex_pc, pc_of(32'hAAAA_0001));
      chk($sformatf("hold%0d_ex_rd", k), 64'(bus.ex_rd), 64'd12);
    end
    drive(mk(1,0,1,1,0,0,0,1,13,1,0,0,0,0,0,0,0,0), 32'hBBBB_0002);
    #4;
    chk("release_id_ready", 64'(bus.id_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("release_ex_valid", 64'(bus.ex_valid), 64'd1);
    chk("release_ex_insn", 64'(bus.ex_insn), 64'hBBBB_0002);
    chk("release_ex_ld", 64'(bus.ex_ld), 64'd1);
    chk("release_pend", 64'(bus.sb_pending), 64'h2000);
    chk("release_stall", 64'(bus.stall_cycles), 64'd3);
    drive(mk(1,1,1,1,0,0,0,1,14,0,0,0,0,0,0,0,0,0), 32'hCCCC_0003);
    #4;
    chk("flush_id_ready", 64'(bus.id_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("flush_ex_valid", 64'(bus.ex_valid), 64'd0);
    chk("flush_pend", 64'(bus.sb_pending), 64'h2000);
    chk("flush_cnt", 64'(bus.ld_outstanding), 64'd1);
    chk("flush_stall", 64'(bus.stall_cycles), 64'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, nerr);
    $finish;
  end
endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Sits between the decode stage (IDU outputs) and the execute stage.
- Holds the single ID->EX pipeline register and issues decoded instructions with a valid/ready handshake.
- Stalls on RAW/WAW hazards against loads still outstanding in the LSU, using a 32-entry scoreboard plus an outstanding-load credit counter.
- ALU results are assumed bypassed by EX, so only loads create scoreboard entries.

Parameters:
- MAX_LD, 2, maximum outstanding loads (issued, not yet written back); legal range 1..15.
- PC_W, 64, width of carried PC.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill ID->EX register contents; block issue this cycle
- id_valid  in  1  decoded instruction present
- id_ready  out  1  issue accepted this cycle
- id_insn  in  32  raw instruction
- id_pc  in  PC_W  instruction PC
- id_rs1_re  in  1  rs1 read enable
- id_rs1_addr  in  5  rs1 index
- id_rs2_re  in  1  rs2 read enable
- id_rs2_addr  in  5  rs2 index
- id_rf_we  in  1  writes rd
- id_rd  in  5  destination index
- id_ld  in  1  instruction is a load
- ex_valid  out  1  EX register holds instruction
- ex_ready  in  1  EX consumes this cycle
- ex_insn  out  32  registered id_insn
- ex_pc  out  PC_W  registered id_pc
- ex_rf_we  out  1  registered id_rf_we
- ex_rd  out  5  registered id_rd
- ex_ld  out  1  registered id_ld
- lsu_wb_valid  in  1  a load writes back this cycle
- lsu_wb_rd  in  5  rd of the writing-back load
- sb_pending  out  32  scoreboard bitmap (bit0 always 0)
- ld_outstanding  out  4  outstanding-load count
- stall_cycles  out  32  perf counter
- sb_err  out  1  sticky protocol error

Behaviour:
- Reset (rst=1 at posedge): all outputs and state are 0, namely ex_valid, ex_* payload, sb_pending, ld_outstanding, stall_cycles and sb_err.
- Hazard terms, evaluated on current-cycle state (registered sb_pending):
  - raw1 = id_rs1_re & rs1!=0 & pend[rs1]
  - raw2 = id_rs2_re & rs2!=0 & pend[rs2]
  - waw = id_rf_we & rd!=0 & pend[rd]
- Credit: no_credit = id_ld & (ld_outstanding==MAX_LD).
- Writeback bypass: none. A same-cycle lsu_wb_valid clearing a bit does NOT unblock issue that cycle; this gives a 1-cycle bubble after writeback.
- Ready equation, combinational: id_ready = id_valid & ~flush & (~ex_valid | ex_ready) & ~raw1 & ~raw2 & ~waw & ~no_credit.
- Issue = id_ready. On issue, the EX register loads all id_* payload next edge and ex_valid becomes 1. Latency is 1 cycle.
- No issue and ex_ready & ex_valid: ex_valid becomes 0 and payload holds.
- No issue and ~ex_ready: ex_valid and payload hold; they must remain stable while ex_valid & ~ex_ready.
- flush:
  - ex_valid becomes 0 next edge; payload is don't-care.
  - Scoreboard and counter are untouched, because in-flight loads still write back.
  - Flush has priority over issue.
- Scoreboard set: on issue with id_ld & id_rf_we & rd!=0, pend[rd] is set at the issue edge, before the load reaches EX.
- Scoreboard clear: on lsu_wb_valid with lsu_wb_rd!=0, pend[lsu_wb_rd] is cleared.
- Set and clear of the same index in the same cycle cannot occur (waw blocks it). If it does, set wins and sb_err is set.
- Counter: +1 on issue of any id_ld (rd==0 included), -1 on lsu_wb_valid; both in one cycle leaves it unchanged.
- Writeback with ld_outstanding==0, or with pend[lsu_wb_rd]==0 and lsu_wb_rd!=0, sets sb_err. sb_err is sticky until rst; the counter saturates at 0.
- Loads to x0 are counted but not scoreboarded; their writeback (rd=0) only decrements the counter.
- stall_cycles increments each cycle id_valid & ~id_ready & ~flush, and wraps at 2^32.
- Reset mid-operation: everything returns to 0, and writebacks of pre-reset loads then raise sb_err. Software/TB must drain the LSU or reset it with this block.

Decomposition:
- Shared package/defines.v:
  - NREG=32
  - REG_IDX_W=5
  - REG_X0=0
  - perf counter width 32
- Sub-module issue_scoreboard:
  - 32-bit pend register with set/clear ports and error detect.
  - Three combinational lookups (rs1, rs2, rd).
- issue_ctrl contains the credit counter, the EX register/handshake and perf.

Test Plan:
- Back-to-back ALU ops (addi x1; add x2,x1,x1), ex_ready=1 -> id_ready=1 both cycles, ex_valid 1 for 2 consecutive cycles, sb_pending=0.
- ld x5 issued, then add x6,x5,x0 held with no wb for 3 cycles -> id_ready=0 for 3 cycles and stall_cycles=3. lsu_wb_valid rd=5 at cycle N -> add issues at N+1, pend[5]=0.
- MAX_LD=2, three independent loads (x1,x2,x3) with no wb -> first two issue, ld_outstanding=2, third stalls. One wb -> third issues the next cycle, count stays 2.
- ex_ready=0 with ex_valid=1 and new id_valid -> id_ready=0, ex_insn/ex_pc stable. ex_ready=1 -> the new instruction is issued the same cycle and ex_valid stays 1.
- flush while ld x7 is in the EX register and pend[7]=1 -> ex_valid=0 next cycle, pend[7] stays 1, ld_outstanding unchanged. Later wb rd=7 clears it with sb_err=0.
- lsu_wb_valid rd=9 with pend[9]=0 -> sb_err=1, and it persists until rst.
